fcmp_pipe: RTL and testbench
============================

Name: fcmp_pipe

Overview:
Parametrised, pipelined floating-point compare/min-max unit for the FPU. It generalises the single-precision combinational equality compare to FEQ/FLT/FLE/FMIN/FMAX over a configurable IEEE-754-style format. Latency is configurable, and a valid/ready handshake with full backpressure is provided. It sits in the FPU execute cluster beside the add/mul pipes and returns a tagged result to writeback.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width; operand width W = 1+EXP_W+MAN_W
LATENCY, 2, register stages from input acceptance to output valid; legal range 1..4
TAG_W, 5, width of the opaque tag (destination register) passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept a beat this cycle
in_op  in  3  fpu_pkg::fcmp_op_t: FEQ=0, FLT=1, FLE=2, FMIN=3, FMAX=4
in_a  in  W  operand a
in_b  in  W  operand b
in_tag  in  TAG_W  passthrough tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_res  out  W  FEQ/FLT/FLE: zero-extended 0/1; FMIN/FMAX: selected operand or canonical NaN
out_nv  out  1  invalid-operation flag
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: all stage valid bits are 0, so out_valid=0. out_res, out_nv and out_tag are 0. in_ready=1 in the first cycle after reset deasserts.
- Accept: a beat is taken when in_valid&&in_ready.
- Advance: global advance en = !out_valid || out_ready; in_ready = en. When en=0 every stage holds, including data and valid bits.
- Latency: an accepted beat appears on out_valid exactly LATENCY cycles later when en stays 1 throughout. Throughput is 1 beat/cycle. Beats stay in order, and none is dropped or duplicated under any out_ready pattern.
- Bubble: a stage with valid=0 takes new data when en=1; no bubble squeezing.
- Classification (stage 0):
  - exp=all-ones, man≠0 → NaN; quiet if man MSB=1, else signalling.
  - exp=0 → zero. Subnormals are flushed to signed zero.
  - otherwise normal or infinity.
- Equality:
  - +0 == −0.
  - Any NaN operand → FEQ=0.
  - Otherwise equal iff bit patterns are equal after the subnormal flush.
- Ordering:
  - Sign-magnitude compare; both zeros compare equal.
  - Any NaN operand → FLT=FLE=0.
- NV flag:
  - FEQ: set iff either operand is a signalling NaN.
  - FLT/FLE: set iff either operand is any NaN.
  - FMIN/FMAX: set iff either operand is a signalling NaN.
- FMIN/FMAX results:
  - One NaN operand → return the other operand.
  - Both NaN → canonical NaN: sign 0, exp all-ones, man MSB only set.
  - −0 is less than +0 for min/max selection only.
  - A flushed subnormal returns signed zero, not the original bits.
- Illegal op codes 5..7: out_res=0, out_nv=0, and the beat still flows with its normal latency.
- Reset mid-operation: all in-flight beats are discarded. out_valid=0 the next cycle regardless of out_ready.
- Simultaneous accept and drain in the same cycle is legal and keeps full throughput.

Decomposition:
- fpu_pkg holds:
  - fcmp_op_t enum;
  - fp_class_t (ZERO, NORM, INF, QNAN, SNAN);
  - canonical-NaN constant function of EXP_W/MAN_W.
- One combinational sub-module, fcmp_core, holds classification, compare and select logic, with no state.
- fcmp_pipe holds the LATENCY-deep valid/data shift register with the global enable. The core sits between the input and stage 0; the remaining stages are pure delay.

Test Plan:
1. FEQ, a=0x3F800000, b=0x3F800000, tag=7, out_ready=1 → after 2 cycles out_valid=1, res=1, nv=0, tag=7. Also FEQ 0x00000000 vs 0x80000000 → res=1.
2. FEQ, a=0x7FC00000, b=0x7FC00000 → res=0, nv=0. FEQ with a=0x7F800001 (signalling NaN) → res=0, nv=1. FLT with a=0x7FC00000 → res=0, nv=1.
3. FLT 0xBF800000 vs 0x3F800000 → 1. FLE 0x40000000 vs 0x40000000 → 1. FLT 0x00000001 vs 0x80000000 → 0 (subnormal flushed).
4. FMIN 0x00000000 vs 0x80000000 → 0x80000000. FMAX 0x7FC00000 vs 0x40400000 → 0x40400000. FMIN of two NaNs → 0x7FC00000.
5. Backpressure: 8 back-to-back beats with out_ready toggling 1,0,0,1,… → all 8 results in order with correct tags. in_ready follows en, and outputs stay stable while out_valid&&!out_ready.
6. Reset asserted with 2 beats in flight → out_valid=0 next cycle, in_ready=1. A fresh beat after reset gives the correct result at LATENCY. Repeat all cases with LATENCY=1 and 4, and with EXP_W=11, MAN_W=52 (e.g. FEQ 0x3FF0000000000000 twice → 1).

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU compare types and the canonical-NaN constant
package fpu_pkg;

    typedef enum logic [2:0] {
        FEQ  = 3'd0,
        FLT  = 3'd1,
        FLE  = 3'd2,
        FMIN = 3'd3,
        FMAX = 3'd4
    } fcmp_op_t;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

    localparam int MAX_FP_W = 128;

    // Positive quiet NaN with only the mantissa MSB set; callers truncate to their width.
    function automatic logic [MAX_FP_W-1:0] canon_nan(input int exp_w, input int man_w);
        logic [MAX_FP_W-1:0] v;
        v = ((MAX_FP_W'(1) << exp_w) - MAX_FP_W'(1)) << man_w;
        v = v | (MAX_FP_W'(1) << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// rtl/fcmp_core.sv - stateless classify / compare / min-max select
module fcmp_core
    import fpu_pkg::*;
#(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output logic         nv_o
);

    localparam logic [W-1:0] CANON_NAN = W'(canon_nan(EXP_W, MAN_W));

    function automatic fp_class_t classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[W-2:MAN_W];
        m = x[MAN_W-1:0];
        if (e == '1) begin
            if (m == '0) return INF;
            return m[MAN_W-1] ? QNAN : SNAN;
        end
        if (e == '0) return ZERO;
        return NORM;
    endfunction

    fp_class_t    cls_a, cls_b;
    logic [W-1:0] fa, fb;
    logic         nan_a, nan_b, any_nan, snan_any, both_zero;
    logic         mag_lt, mag_gt, lt_total, lt_num, eq_num;

    assign cls_a = classify(a_i);
    assign cls_b = classify(b_i);

    // Subnormals collapse to a zero that keeps its sign.
    assign fa = (cls_a == ZERO) ? {a_i[W-1], {(W-1){1'b0}}} : a_i;
    assign fb = (cls_b == ZERO) ? {b_i[W-1], {(W-1){1'b0}}} : b_i;

    assign nan_a     = (cls_a == QNAN) || (cls_a == SNAN);
    assign nan_b     = (cls_b == QNAN) || (cls_b == SNAN);
    assign any_nan   = nan_a || nan_b;
    assign snan_any  = (cls_a == SNAN) || (cls_b == SNAN);
    assign both_zero = (cls_a == ZERO) && (cls_b == ZERO);

    // lt_total orders -0 below +0; lt_num is the numeric relation where zeros tie.
    assign mag_lt   = fa[W-2:0] < fb[W-2:0];
    assign mag_gt   = fa[W-2:0] > fb[W-2:0];
    assign lt_total = (fa[W-1] != fb[W-1]) ? fa[W-1] : (fa[W-1] ? mag_gt : mag_lt);
    assign lt_num   = lt_total && !both_zero;
    assign eq_num   = both_zero || (fa == fb);

    always_comb begin
        res_o = '0;
        nv_o  = 1'b0;
        case (fcmp_op_t'(op_i))
            FEQ: begin
                res_o = W'(!any_nan && eq_num);
                nv_o  = snan_any;
            end
            FLT: begin
                res_o = W'(!any_nan && lt_num);
                nv_o  = any_nan;
            end
            FLE: begin
                res_o = W'(!any_nan && (lt_num || eq_num));
                nv_o  = any_nan;
            end
            FMIN, FMAX: begin
                nv_o = snan_any;
                if (nan_a && nan_b)                                res_o = CANON_NAN;
                else if (nan_a)                                    res_o = fb;
                else if (nan_b)                                    res_o = fa;
                else if ((fcmp_op_t'(op_i) == FMIN) == lt_total)  res_o = fa;
                else                                               res_o = fb;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - pipelined FP compare/min-max with valid/ready and tag passthrough
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int  EXP_W   = 8,
    parameter int  MAN_W   = 23,
    parameter int  LATENCY = 2,
    parameter int  TAG_W   = 5,
    localparam int W       = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
);

    logic [LATENCY-1:0]            valid_q, valid_d;
    logic [LATENCY-1:0][W-1:0]     res_q, res_d;
    logic [LATENCY-1:0]            nv_q, nv_d;
    logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [W-1:0]                  core_res;
    logic                          core_nv;
    logic                          en;

    fcmp_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .op_i  (in_op),
        .a_i   (in_a),
        .b_i   (in_b),
        .res_o (core_res),
        .nv_o  (core_nv)
    );

    // One enable freezes the whole pipe; empty stages are not squeezed out.
    assign en       = !valid_q[LATENCY-1] || out_ready;
    assign in_ready = en;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        nv_d    = nv_q;
        tag_d   = tag_q;
        if (en) begin
            valid_d[0] = in_valid;
            res_d[0]   = core_res;
            nv_d[0]    = core_nv;
            tag_d[0]   = in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                res_d[i]   = res_q[i-1];
                nv_d[i]    = nv_q[i-1];
                tag_d[i]   = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            res_q   <= '0;
            nv_q    <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            nv_q    <= nv_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_res   = res_q[LATENCY-1];
    assign out_nv    = nv_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb/tb_fcmp_pipe.sv - randomized scoreboard bench over three fcmp_pipe configurations
module tb_fcmp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model: numeric view of the operands ----------------
    function automatic logic [63:0] fexp(input logic [63:0] x, input int ew, input int mw);
        return (x >> mw) & ((64'd1 << ew) - 64'd1);
    endfunction
    function automatic logic [63:0] fman(input logic [63:0] x, input int mw);
        return x & ((64'd1 << mw) - 64'd1);
    endfunction
    function automatic logic fsgn(input logic [63:0] x, input int ew, input int mw);
        return x[ew+mw];
    endfunction
    function automatic logic is_nan(input logic [63:0] x, input int ew, input int mw);
        return (fexp(x, ew, mw) == (64'd1 << ew) - 64'd1) && (fman(x, mw) != 0);
    endfunction
    function automatic logic is_snan(input logic [63:0] x, input int ew, input int mw);
        return is_nan(x, ew, mw) && (((fman(x, mw) >> (mw - 1)) & 64'd1) == 0);
    endfunction
    function automatic logic is_inf(input logic [63:0] x, input int ew, input int mw);
        return (fexp(x, ew, mw) == (64'd1 << ew) - 64'd1) && (fman(x, mw) == 0);
    endfunction
    function automatic logic [63:0] flush(input logic [63:0] x, input int ew, input int mw);
        if (fexp(x, ew, mw) == 0) return {63'd0, fsgn(x, ew, mw)} << (ew + mw);
        return x;
    endfunction
    function automatic real fval(input logic [63:0] x, input int ew, input int mw);
        real rm, v;
        int  e, bias;
        e    = int'(fexp(x, ew, mw));
        bias = (1 << (ew - 1)) - 1;
        if (e == 0) return 0.0;
        rm = fman(x, mw);
        v  = (1.0 + rm / (2.0 ** mw)) * (2.0 ** (e - bias));
        return fsgn(x, ew, mw) ? -v : v;
    endfunction
    function automatic logic less(input logic [63:0] a, input logic [63:0] b, input int ew, input int mw);
        logic ia, ib, sa, sb;
        ia = is_inf(a, ew, mw); ib = is_inf(b, ew, mw);
        sa = fsgn(a, ew, mw);   sb = fsgn(b, ew, mw);
        if (ia && ib) return sa && !sb;
        if (ia) return sa;
        if (ib) return !sb;
        return fval(a, ew, mw) < fval(b, ew, mw);
    endfunction

    // returns {nv, res}
    function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                          input int ew, input int mw);
        logic [63:0] res, fa, fb, canon;
        logic        nv, na, nb, sn, lab, lba, eq;
        na  = is_nan(a, ew, mw);
        nb  = is_nan(b, ew, mw);
        sn  = is_snan(a, ew, mw) || is_snan(b, ew, mw);
        fa  = flush(a, ew, mw);
        fb  = flush(b, ew, mw);
        lab = !na && !nb && less(a, b, ew, mw);
        lba = !na && !nb && less(b, a, ew, mw);
        eq  = !na && !nb && !lab && !lba;
        canon = (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
        res = 64'd0;
        nv  = 1'b0;
        case (op)
            3'd0: begin res = {63'd0, eq};        nv = sn; end
            3'd1: begin res = {63'd0, lab};       nv = na || nb; end
            3'd2: begin res = {63'd0, lab || eq}; nv = na || nb; end
            3'd3, 3'd4: begin
                nv = sn;
                if (na && nb)  res = canon;
                else if (na)   res = fb;
                else if (nb)   res = fa;
                else if (lab)  res = (op == 3'd3) ? fa : fb;
                else if (lba)  res = (op == 3'd3) ? fb : fa;
                else           res = ((op == 3'd3) == fsgn(a, ew, mw)) ? fa : fb;
            end
            default: ;
        endcase
        return {nv, res};
    endfunction

    function automatic logic [63:0] mk(input logic s, input logic [63:0] e, input logic [63:0] m,
                                       input int ew, input int mw);
        return ({63'd0, s} << (ew + mw)) | ((e & ((64'd1 << ew) - 64'd1)) << mw) | (m & ((64'd1 << mw) - 64'd1));
    endfunction

    function automatic logic [63:0] rnd_fp(input int ew, input int mw);
        logic [63:0] r, em, bias, top;
        logic        s;
        r    = {$urandom, $urandom};
        s    = 1'($urandom);
        em   = (64'd1 << ew) - 64'd1;
        bias = (64'd1 << (ew - 1)) - 64'd1;
        top  = 64'd1 << (mw - 1);
        case ($urandom % 8)
            0:       return mk(s, 64'd0, 64'd0, ew, mw);
            1:       return mk(s, 64'd0, r, ew, mw);
            2:       return mk(s, em, 64'd0, ew, mw);
            3:       return mk(s, em, r | top, ew, mw);
            4:       return mk(s, em, (r & (top - 64'd1)) | 64'd1, ew, mw);
            5:       return mk(s, bias + 64'($urandom % 2), top & {64{r[0]}}, ew, mw);
            default: return mk(s, r >> 40, r, ew, mw);
        endcase
    endfunction

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        nv;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        nv;
        logic [4:0]  tag;
        int          cyc;
        int          st;
    } exp_t;

    localparam int NSP = 16;
    localparam int NDP = 6;

    vec_t sp_vec [NSP] = '{
        '{3'd0, 64'h3F800000, 64'h3F800000, 64'h1,        1'b0},
        '{3'd0, 64'h00000000, 64'h80000000, 64'h1,        1'b0},
        '{3'd0, 64'h7FC00000, 64'h7FC00000, 64'h0,        1'b0},
        '{3'd0, 64'h7F800001, 64'h3F800000, 64'h0,        1'b1},
        '{3'd1, 64'h7FC00000, 64'h3F800000, 64'h0,        1'b1},
        '{3'd1, 64'hBF800000, 64'h3F800000, 64'h1,        1'b0},
        '{3'd2, 64'h40000000, 64'h40000000, 64'h1,        1'b0},
        '{3'd1, 64'h00000001, 64'h80000000, 64'h0,        1'b0},
        '{3'd3, 64'h00000000, 64'h80000000, 64'h80000000, 1'b0},
        '{3'd4, 64'h7FC00000, 64'h40400000, 64'h40400000, 1'b0},
        '{3'd3, 64'h7FC00000, 64'h7FC00001, 64'h7FC00000, 1'b0},
        '{3'd3, 64'h7F800001, 64'h7FC00000, 64'h7FC00000, 1'b1},
        '{3'd4, 64'h00000001, 64'h80000000, 64'h00000000, 1'b0},
        '{3'd5, 64'h3F800000, 64'h3F800000, 64'h0,        1'b0},
        '{3'd3, 64'hFF800000, 64'h3F800000, 64'hFF800000, 1'b0},
        '{3'd2, 64'h3F800000, 64'hFF800000, 64'h0,        1'b0}
    };

    vec_t dp_vec [NDP] = '{
        '{3'd0, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h1,                1'b0},
        '{3'd1, 64'hBFF0000000000000, 64'h3FF0000000000000, 64'h1,                1'b0},
        '{3'd4, 64'h7FF8000000000000, 64'h4008000000000000, 64'h4008000000000000, 1'b0},
        '{3'd3, 64'h7FF8000000000000, 64'h7FF0000000000001, 64'h7FF8000000000000, 1'b1},
        '{3'd3, 64'h0000000000000000, 64'h8000000000000000, 64'h8000000000000000, 1'b0},
        '{3'd2, 64'h0000000000000001, 64'h8000000000000000, 64'h1,                1'b0}
    };

    // ---------------- three DUT configurations, each with its own driver and scoreboard ----------------
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int EW  = (g == 2) ? 11 : 8;
        localparam int MW  = (g == 2) ? 52 : 23;
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int W   = 1 + EW + MW;

        logic         rst, in_valid, in_ready, out_valid, out_ready, out_nv;
        logic [2:0]   in_op;
        logic [W-1:0] in_a, in_b, out_res;
        logic [4:0]   in_tag, out_tag;
        logic         fin = 1'b0;

        fcmp_pipe #(
            .EXP_W   (EW),
            .MAN_W   (MW),
            .LATENCY (LAT),
            .TAG_W   (5)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_op     (in_op),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_tag    (in_tag),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_res   (out_res),
            .out_nv    (out_nv),
            .out_tag   (out_tag)
        );

        function automatic string nm(input string s);
            return $sformatf("u%0d.%s", g, s);
        endfunction

        exp_t         q[$];
        exp_t         e, ne;
        logic [64:0]  mres;
        int           cyc    = 0;
        int           stalls = 0;
        int           bp_cnt = 0;
        logic         hold   = 1'b0;
        logic [W-1:0] h_res;
        logic         h_nv;
        logic [4:0]   h_tag;

        always @(negedge clk) begin
            cyc++;
            if (rst) begin
                q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk(nm("hold_valid"), 64'(out_valid), 64'd1);
                    chk(nm("hold_res"), 64'(out_res), 64'(h_res));
                    chk(nm("hold_nv"), 64'(out_nv), 64'(h_nv));
                    chk(nm("hold_tag"), 64'(out_tag), 64'(h_tag));
                end
                chk(nm("in_ready"), 64'(in_ready), 64'(!out_valid || out_ready));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk(nm("unexpected_out"), 64'(out_valid), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk(nm("res"), 64'(out_res), e.res);
                        chk(nm("nv"), 64'(out_nv), 64'(e.nv));
                        chk(nm("tag"), 64'(out_tag), 64'(e.tag));
                        chk(nm("latency"), 64'(cyc - e.cyc - (stalls - e.st)), 64'(LAT));
                    end
                end else if (out_valid) begin
                    stalls++;
                end
                if (in_valid && in_ready) begin
                    mres   = model(in_op, 64'(in_a), 64'(in_b), EW, MW);
                    ne.res = mres[63:0];
                    ne.nv  = mres[64];
                    ne.tag = in_tag;
                    ne.cyc = cyc;
                    ne.st  = stalls;
                    q.push_back(ne);
                end
                hold  = out_valid && !out_ready;
                h_res = out_res;
                h_nv  = out_nv;
                h_tag = out_tag;
            end
        end

        function automatic logic pick_ready(input int mode);
            if (mode == 0) return 1'b1;
            if (mode == 1) return (bp_cnt % 3) == 0;
            return 1'($urandom);
        endfunction

        task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] tag, input int mode);
            logic acc;
            acc      = 1'b0;
            in_valid = 1'b1;
            in_op    = op;
            in_a     = a;
            in_b     = b;
            in_tag   = tag;
            for (int t = 0; t < 100; t++) begin
                out_ready = pick_ready(mode);
                bp_cnt++;
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                if (acc) break;
            end
            chk(nm("accept"), 64'(acc), 64'd1);
            in_valid = 1'b0;
        endtask

        task automatic drain();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
            #1;
            chk(nm("drain"), 64'(q.size()), 64'd0);
        endtask

        initial begin
            vec_t v;
            rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk(nm("rst_valid"), 64'(out_valid), 64'd0);
            chk(nm("rst_res"), 64'(out_res), 64'd0);
            chk(nm("rst_nv"), 64'(out_nv), 64'd0);
            chk(nm("rst_tag"), 64'(out_tag), 64'd0);
            chk(nm("rst_in_ready"), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            for (int i = 0; i < ((g == 2) ? NDP : NSP); i++) begin
                v = (g == 2) ? dp_vec[i] : sp_vec[i];
                send(v.op, W'(v.a), W'(v.b), 5'(i + 7), 0);
            end
            for (int i = 0; i < 8; i++)
                send(3'($urandom % 5), W'(rnd_fp(EW, MW)), W'(rnd_fp(EW, MW)), 5'(i), 1);
            for (int i = 0; i < 300; i++) begin
                if ($urandom % 4 == 0) begin
                    out_ready = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                send(3'($urandom % 8), W'(rnd_fp(EW, MW)), W'(rnd_fp(EW, MW)), 5'($urandom), 2);
            end
            drain();
            send(3'd0, W'(rnd_fp(EW, MW)), W'(rnd_fp(EW, MW)), 5'd1, 0);
            send(3'd4, W'(rnd_fp(EW, MW)), W'(rnd_fp(EW, MW)), 5'd2, 0);
            rst = 1'b1;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk(nm("midrst_valid"), 64'(out_valid), 64'd0);
            rst = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk(nm("postrst_valid"), 64'(out_valid), 64'd0);
            chk(nm("postrst_in_ready"), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            v = (g == 2) ? dp_vec[0] : sp_vec[0];
            send(v.op, W'(v.a), W'(v.b), 5'd19, 0);
            drain();
            fin = 1'b1;
        end
    end

    initial begin
        logic [64:0] m;
        for (int i = 0; i < NSP; i++) begin
            m = model(sp_vec[i].op, sp_vec[i].a, sp_vec[i].b, 8, 23);
            chk($sformatf("pin_sp%0d", i), {63'd0, m[64]}, {63'd0, sp_vec[i].nv});
            chk($sformatf("pin_sp%0d_res", i), m[63:0], sp_vec[i].res);
        end
        for (int i = 0; i < NDP; i++) begin
            m = model(dp_vec[i].op, dp_vec[i].a, dp_vec[i].b, 11, 52);
            chk($sformatf("pin_dp%0d", i), {63'd0, m[64]}, {63'd0, dp_vec[i].nv});
            chk($sformatf("pin_dp%0d_res", i), m[63:0], dp_vec[i].res);
        end
        for (int t = 0; t < 20000; t++) begin
            if (u[0].fin && u[1].fin && u[2].fin) break;
            @(posedge clk);
        end
        chk("all_done", {61'd0, u[2].fin, u[1].fin, u[0].fin}, 64'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
